// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 32'd4;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 32'd1) ? $clog2(width) : 32'd1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: D = A - B - Bin, Bout is the borrow out.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor_4bits.sv
// Bit-serial A - B - Bin, one bit per enabled clock, LSB first, with a
// start/busy/done handshake and a registered {borrow, difference} result.
module serial_subtractor_4bits
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   D
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   d_q, d_d;
    logic             done_q, done_d;

    logic             bit_d_s;
    logic             bit_bout_s;

    full_subtractor u_fs (
        .A    (a_sr_q[0]),
        .B    (b_sr_q[0]),
        .Bin  (borrow_q),
        .D    (bit_d_s),
        .Bout (bit_bout_s)
    );

    // Next-state logic: everything holds unless enable is high.
    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        diff_sr_d = diff_sr_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        done_d    = done_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    done_d = 1'b0;
                    if (start) begin
                        state_d   = RUN;
                        a_sr_d    = A;
                        b_sr_d    = B;
                        borrow_d  = Bin;
                        diff_sr_d = '0;
                        cnt_d     = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
                    diff_sr_d = {bit_d_s, diff_sr_q[WIDTH-1:1]};
                    borrow_d  = bit_bout_s;
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        // Final bit: publish the whole result in one step.
                        state_d = IDLE;
                        d_d     = {bit_bout_s, bit_d_s, diff_sr_q[WIDTH-1:1]};
                        done_d  = 1'b1;
                    end else begin
                        done_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            diff_sr_q <= '0;
            borrow_q  <= 1'b0;
            cnt_q     <= '0;
            d_q       <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            diff_sr_q <= diff_sr_d;
            borrow_q  <= borrow_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign D    = d_q;

endmodule

// File: tb/tb_serial_subtractor_4bits.sv
// Directed and exhaustive checks of the bit-serial subtractor handshake and results.
module tb_serial_subtractor_4bits;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   D;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[6];

    serial_subtractor_4bits #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .start  (start),
        .A      (A),
        .B      (B),
        .Bin    (Bin),
        .busy   (busy),
        .done   (done),
        .D      (D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count enabled-or-not edges until done rises, bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cycles++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL wait_done: done never rose within 20 cycles");
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic bin, input logic [4:0] exp);
        int c;
        A = a; B = b; Bin = bin; start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(c);
        check({name, "_lat"}, c, 32'd4);
        check({name, "_D"}, {27'd0, D}, {27'd0, exp});
        check({name, "_busy_end"}, {31'd0, busy}, 32'd0);
        tick();
        check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int c1;
        int c2;
        logic [4:0] d_hold;
        logic [4:0] model;
        n_compared = 0;
        n_mismatched = 0;

        vecs[0] = '{4'd9,  4'd3,  1'b0, 5'b0_0110};
        vecs[1] = '{4'd3,  4'd9,  1'b0, 5'b1_1010};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 5'b1_1111};
        vecs[3] = '{4'd15, 4'd15, 1'b0, 5'b0_0000};
        vecs[4] = '{4'd0,  4'd15, 1'b1, 5'b1_0000};
        vecs[5] = '{4'd15, 4'd0,  1'b1, 5'b0_1110};

        reset = 1'b1; enable = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_D", {27'd0, D}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp);

        // Start held high: second op is accepted in the first done cycle,
        // so completions are WIDTH+1 edges apart.
        A = 4'd7; B = 4'd2; Bin = 1'b0; start = 1'b1;
        tick();
        A = 4'd2; B = 4'd7;
        wait_done(c1);
        check("b2b_lat1", c1, 32'd4);
        check("b2b_D1", {27'd0, D}, {27'd0, 5'b0_0101});
        tick();
        check("b2b_accept_busy", {31'd0, busy}, 32'd1);
        check("b2b_done_clr", {31'd0, done}, 32'd0);
        start = 1'b0;
        wait_done(c2);
        check("b2b_spacing", c2 + 1, 32'd5);
        check("b2b_D2", {27'd0, D}, {27'd0, 5'b1_1011});
        tick();

        // 12-5 with an ignored start and a 3-cycle enable gap.
        d_hold = D;
        A = 4'd12; B = 4'd5; Bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        A = 4'd1; B = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en_busy_hold", {31'd0, busy}, 32'd1);
            check("en_D_hold", {27'd0, D}, {27'd0, d_hold});
            check("en_done_low", {31'd0, done}, 32'd0);
        end
        enable = 1'b1;
        wait_done(c1);
        check("en_lat", c1 + 5, 32'd7);
        check("en_D", {27'd0, D}, {27'd0, 5'b0_0111});
        enable = 1'b0;
        tick();
        tick();
        check("en_done_stretch", {31'd0, done}, 32'd1);
        enable = 1'b1;
        tick();
        check("en_done_clr", {31'd0, done}, 32'd0);

        // Asynchronous reset two bits into 14-1.
        A = 4'd14; B = 4'd1; Bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_D", {27'd0, D}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("arst_no_done", {31'd0, done}, 32'd0);
        run_op("post_rst", 4'd6, 4'd6, 1'b0, 5'b0_0000);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    model = 5'(a) - 5'(b) - 5'(bi);
                    run_op($sformatf("ex_%0d_%0d_%0d", a, b, bi), 4'(a), 4'(b), 1'(bi), model);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
